// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the 16-bit FunSel register driver:
// FunSel codes, op codes, FSM states and the per-op E-cycle count.
package reg_ctrl_pkg;

  localparam int unsigned COUNT_W_DEF = 8;

  typedef enum logic [2:0] {
    FS_DEC      = 3'b000,
    FS_INC      = 3'b001,
    FS_LOAD     = 3'b010,
    FS_CLR      = 3'b011,
    FS_LDLO_CLR = 3'b100,
    FS_WRLO     = 3'b101,
    FS_WRHI     = 3'b110,
    FS_SEXT     = 3'b111
  } funsel_e;

  typedef enum logic [2:0] {
    OP_LOAD       = 3'd0,
    OP_LOAD_BYTES = 3'd1,
    OP_INC_N      = 3'd2,
    OP_DEC_N      = 3'd3,
    OP_CLEAR      = 3'd4,
    OP_SEXT8      = 3'd5,
    OP_LOAD_LO    = 3'd6,
    OP_READ       = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Number of E cycles an op needs; INC_N/DEC_N with N=0 need none.
  function automatic logic [15:0] op_cycles(input op_e op, input logic [15:0] n);
    logic [15:0] k;
    k = 16'd1;
    case (op)
      OP_LOAD_BYTES:      k = 16'd2;
      OP_INC_N, OP_DEC_N: k = n;
      OP_READ:            k = 16'd0;
      default:            k = 16'd1;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/reg_expect_calc.sv
// Combinational model of the register value expected after a command,
// from the latched op, operand, repeat count and captured Q.
module reg_expect_calc
  import reg_ctrl_pkg::*;
(
  input  op_e         op_i,
  input  logic [15:0] data_i,
  input  logic [15:0] n_i,
  input  logic [15:0] qcap_i,
  output logic [15:0] exp_o
);

  always_comb begin
    exp_o = qcap_i;
    case (op_i)
      OP_LOAD:       exp_o = data_i;
      OP_LOAD_BYTES: exp_o = data_i;
      OP_INC_N:      exp_o = qcap_i + n_i;
      OP_DEC_N:      exp_o = qcap_i - n_i;
      OP_CLEAR:      exp_o = '0;
      OP_SEXT8:      exp_o = {{8{data_i[7]}}, data_i[7:0]};
      OP_LOAD_LO:    exp_o = {qcap_i[15:8], data_i[7:0]};
      OP_READ:       exp_o = qcap_i;
      default:       exp_o = qcap_i;
    endcase
  end

endmodule

// File: rtl/reg_funsel_driver.sv
// Initiator for the FunSel/E/I/Q register interface: runs one command per
// handshake, reads Q back after the last write and reports it with a check flag.
module reg_funsel_driver
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W  = COUNT_W_DEF,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic [2:0]         CmdOp,
  input  logic [15:0]        CmdData,
  input  logic [COUNT_W-1:0] CmdCount,
  output logic [2:0]         FunSel,
  output logic               E,
  output logic [15:0]        I,
  input  logic [15:0]        Q,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [15:0]        RspData,
  output logic               RspErr
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [15:0] data_q, n_q, qcap_q, left_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic [15:0] n_cmd, k_cmd, exp_w;
  logic        accept;
  funsel_e     fs;

  assign n_cmd  = 16'(CmdCount);
  assign k_cmd  = op_cycles(op_e'(CmdOp), n_cmd);
  assign accept = (state_q == ST_IDLE) && CmdValid;

  reg_expect_calc u_expect (
    .op_i   (op_q),
    .data_i (data_q),
    .n_i    (n_q),
    .qcap_i (qcap_q),
    .exp_o  (exp_w)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (CmdValid) state_d = (k_cmd == 16'd0) ? ST_CHECK : ST_EXEC;
      ST_EXEC:  if (left_q == 16'd1) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_RESP;
      ST_RESP:  if (RspReady) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q       <= OP_LOAD;
      data_q     <= '0;
      n_q        <= '0;
      qcap_q     <= '0;
      left_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(CmdOp);
        data_q <= CmdData;
        n_q    <= n_cmd;
        qcap_q <= Q;
        left_q <= k_cmd;
      end
      if (state_q == ST_EXEC) left_q <= left_q - 16'd1;
      if (state_q == ST_CHECK) begin
        rsp_data_q <= Q;
        rsp_err_q  <= CHECK_EN && (Q != exp_w);
      end
    end
  end

  // Register-side outputs depend only on registered state, never on Cmd* inputs.
  always_comb begin
    fs = FS_DEC;
    E  = 1'b0;
    I  = '0;
    if (state_q == ST_EXEC) begin
      E = 1'b1;
      case (op_q)
        OP_LOAD: begin
          fs = FS_LOAD;
          I  = data_q;
        end
        OP_LOAD_BYTES: begin
          if (left_q == 16'd2) begin
            fs = FS_LDLO_CLR;
            I  = {8'h00, data_q[7:0]};
          end else begin
            fs = FS_WRHI;
            I  = {8'h00, data_q[15:8]};
          end
        end
        OP_INC_N:   fs = FS_INC;
        OP_DEC_N:   fs = FS_DEC;
        OP_CLEAR:   fs = FS_CLR;
        OP_SEXT8: begin
          fs = FS_SEXT;
          I  = {8'h00, data_q[7:0]};
        end
        OP_LOAD_LO: begin
          fs = FS_WRLO;
          I  = {8'h00, data_q[7:0]};
        end
        default: begin
          fs = FS_DEC;
          E  = 1'b0;
        end
      endcase
    end
  end

  assign FunSel   = fs;
  assign CmdReady = (state_q == ST_IDLE);
  assign RspValid = (state_q == ST_RESP);
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_reg_funsel_driver.sv
// Bench for reg_funsel_driver: a real FunSel register hangs off FunSel/E/I/Q,
// expected responses go through a scoreboard queue.
module tb_reg_funsel_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdOp = 3'd0;
  logic [15:0] CmdData = 16'h0000;
  logic [7:0]  CmdCount = 8'd0;
  logic [2:0]  FunSel;
  logic        E;
  logic [15:0] I;
  logic [15:0] Q;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [15:0] RspData;
  logic        RspErr;

  logic [15:0] reg_val = 16'h0000;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0000;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  reg_funsel_driver #(
    .COUNT_W  (8),
    .CHECK_EN (1'b1)
  ) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdData  (CmdData),
    .CmdCount (CmdCount),
    .FunSel   (FunSel),
    .E        (E),
    .I        (I),
    .Q        (Q),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspErr   (RspErr)
  );

  // The attached register; it has no reset of its own.
  always @(posedge clk) begin
    if (E === 1'b1) begin
      case (FunSel)
        3'b000: reg_val <= reg_val - 16'd1;
        3'b001: reg_val <= reg_val + 16'd1;
        3'b010: reg_val <= I;
        3'b011: reg_val <= 16'h0000;
        3'b100: reg_val <= {8'h00, I[7:0]};
        3'b101: reg_val <= {reg_val[15:8], I[7:0]};
        3'b110: reg_val <= {I[7:0], reg_val[7:0]};
        3'b111: reg_val <= {{8{I[7]}}, I[7:0]};
        default: reg_val <= reg_val;
      endcase
    end
  end

  assign Q = ovr_en ? ovr_val : reg_val;

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data, input logic [7:0] cnt,
                        input logic [15:0] exp_q, input int unsigned k,
                        input logic [2:0] fs0, input logic [2:0] fs1,
                        input int unsigned hold, input bit corrupt);
    int unsigned lat;
    int unsigned e_cnt;
    bit          seen;
    rsp_t        exp_r;
    logic [15:0] held_d;
    logic        held_e;
    logic [2:0]  fs_want;
    exp_r.data = corrupt ? (exp_q ^ 16'h00F0) : exp_q;
    exp_r.err  = corrupt;
    sb.push_back(exp_r);
    @(negedge clk);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    CmdCount = cnt;
    for (int i = 0; i < 20 && CmdReady !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (CmdReady !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait op=%0d got=%b want=1", op, CmdReady);
    end
    @(posedge clk);
    #1;
    CmdValid = 1'b0;
    if (corrupt) begin
      ovr_val = exp_q ^ 16'h00F0;
      ovr_en  = 1'b1;
    end
    lat = 0;
    e_cnt = 0;
    seen = 1'b0;
    while (!seen && lat < k + 10) begin
      @(negedge clk);
      lat++;
      if (E === 1'b1) begin
        fs_want = (e_cnt == 0) ? fs0 : fs1;
        vectors++;
        if (FunSel !== fs_want) begin
          miscompares++;
          $display("FAIL funsel op=%0d ecycle=%0d got=%b want=%b", op, e_cnt, FunSel, fs_want);
        end
        e_cnt++;
      end
      if (RspValid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || lat != k + 2) begin
      miscompares++;
      $display("FAIL rsp_latency op=%0d got=%0d seen=%b want=%0d", op, lat, seen, k + 2);
    end
    vectors++;
    if (e_cnt != k) begin
      miscompares++;
      $display("FAIL e_cycles op=%0d got=%0d want=%0d", op, e_cnt, k);
    end
    if (!seen) begin
      sb.delete();
      ovr_en = 1'b0;
    end else begin
      held_d = RspData;
      held_e = RspErr;
      for (int c = 0; c < int'(hold); c++) begin
        CmdValid = (c == 1);
        CmdOp    = 3'd4;
        @(negedge clk);
        vectors++;
        if (RspValid !== 1'b1 || RspData !== held_d || RspErr !== held_e ||
            CmdReady !== 1'b0 || E !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_stable cyc=%0d got v=%b d=%h e=%b rdy=%b E=%b want v=1 d=%h e=%b rdy=0 E=0",
                   c, RspValid, RspData, RspErr, CmdReady, E, held_d, held_e);
        end
      end
      CmdValid = 1'b0;
      exp_r = sb.pop_front();
      vectors++;
      if (RspData !== exp_r.data) begin
        miscompares++;
        $display("FAIL rsp_data op=%0d got=%h want=%h", op, RspData, exp_r.data);
      end
      vectors++;
      if (RspErr !== exp_r.err) begin
        miscompares++;
        $display("FAIL rsp_err op=%0d got=%b want=%b", op, RspErr, exp_r.err);
      end
      RspReady = 1'b1;
      @(posedge clk);
      #1;
      RspReady = 1'b0;
      ovr_en   = 1'b0;
      vectors++;
      if (RspValid !== 1'b0 || CmdReady !== 1'b1) begin
        miscompares++;
        $display("FAIL drain op=%0d got v=%b rdy=%b want v=0 rdy=1", op, RspValid, CmdReady);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({E, FunSel, I, RspValid, RspData, RspErr, CmdReady} !== {1'b0, 3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state got E=%b fs=%b I=%h v=%b d=%h e=%b rdy=%b want all 0, rdy=1",
               E, FunSel, I, RspValid, RspData, RspErr, CmdReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_bytes();
    do_cmd(3'd1, 16'hA5C3, 8'd77, 16'hA5C3, 2, 3'b100, 3'b110, 0, 1'b0);
  endtask

  task automatic test_inc_wrap();
    do_cmd(3'd0, 16'hFFFE, 8'd77, 16'hFFFE, 1, 3'b010, 3'b010, 0, 1'b0);
    do_cmd(3'd2, 16'h0000, 8'd3, 16'h0001, 3, 3'b001, 3'b001, 0, 1'b0);
  endtask

  task automatic test_dec_zero();
    do_cmd(3'd0, 16'h0000, 8'd77, 16'h0000, 1, 3'b010, 3'b010, 0, 1'b0);
    do_cmd(3'd3, 16'h0000, 8'd0, 16'h0000, 0, 3'b000, 3'b000, 0, 1'b0);
    do_cmd(3'd3, 16'h0000, 8'd1, 16'hFFFF, 1, 3'b000, 3'b000, 0, 1'b0);
  endtask

  task automatic test_byte_ops();
    do_cmd(3'd0, 16'h1234, 8'd77, 16'h1234, 1, 3'b010, 3'b010, 0, 1'b0);
    do_cmd(3'd5, 16'h0080, 8'd77, 16'hFF80, 1, 3'b111, 3'b111, 0, 1'b0);
    do_cmd(3'd6, 16'h0011, 8'd77, 16'hFF11, 1, 3'b101, 3'b101, 0, 1'b0);
    do_cmd(3'd7, 16'h0000, 8'd77, 16'hFF11, 0, 3'b000, 3'b000, 0, 1'b0);
    do_cmd(3'd4, 16'hBEEF, 8'd77, 16'h0000, 1, 3'b011, 3'b011, 0, 1'b0);
  endtask

  // A CLEAR pulsed during the held response must be dropped.
  task automatic test_back_to_back();
    do_cmd(3'd0, 16'h5A5A, 8'd77, 16'h5A5A, 1, 3'b010, 3'b010, 5, 1'b0);
    do_cmd(3'd7, 16'h0000, 8'd77, 16'h5A5A, 0, 3'b000, 3'b000, 0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    int unsigned e_seen;
    do_cmd(3'd0, 16'h0100, 8'd77, 16'h0100, 1, 3'b010, 3'b010, 0, 1'b0);
    @(negedge clk);
    CmdValid = 1'b1;
    CmdOp    = 3'd2;
    CmdCount = 8'd200;
    @(posedge clk);
    #1;
    CmdValid = 1'b0;
    e_seen = 0;
    for (int i = 0; i < 60 && e_seen < 50; i++) begin
      @(negedge clk);
      if (E === 1'b1) e_seen++;
    end
    vectors++;
    if (e_seen != 50) begin
      miscompares++;
      $display("FAIL mid_exec_e_count got=%0d want=50", e_seen);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (E !== 1'b0 || FunSel !== 3'b000 || CmdReady !== 1'b1 || RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_exec_reset got E=%b fs=%b rdy=%b v=%b want E=0 fs=000 rdy=1 v=0",
               E, FunSel, CmdReady, RspValid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (RspValid !== 1'b0 || E !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_exec_quiet cyc=%0d got v=%b E=%b want 0 0", i, RspValid, E);
      end
    end
    do_cmd(3'd7, 16'h0000, 8'd77, 16'h0132, 0, 3'b000, 3'b000, 0, 1'b0);
  endtask

  task automatic test_mismatch();
    do_cmd(3'd0, 16'h1234, 8'd77, 16'h1234, 1, 3'b010, 3'b010, 0, 1'b0);
    do_cmd(3'd7, 16'h0000, 8'd77, 16'h1234, 0, 3'b000, 3'b000, 0, 1'b1);
    do_cmd(3'd7, 16'h0000, 8'd77, 16'h1234, 0, 3'b000, 3'b000, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_bytes();
    test_inc_wrap();
    test_dec_zero();
    test_byte_ops();
    test_back_to_back();
    test_reset_mid_exec();
    test_mismatch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
